// File: rtl/hakutpu_pkg.sv
// Constants and arithmetic helpers shared by the DSP wrapper and the
// drain/requant blocks.
package hakutpu_pkg;

  localparam int HK_P_WIDTH   = 48;
  localparam int HK_OUT_WIDTH = 32;

  localparam logic signed [HK_P_WIDTH:0] HK_ONE = 1;

  typedef struct packed {
    logic                         sat;
    logic signed [HK_P_WIDTH:0]   val;
  } rss_t;

  // Round half toward +inf, arithmetic shift, then clamp to a signed ow-bit range.
  // The extra headroom bit keeps the rounding add from wrapping.
  function automatic rss_t round_shift_sat(input logic signed [HK_P_WIDTH-1:0] x,
                                           input logic [5:0] sh,
                                           input int ow);
    logic signed [HK_P_WIDTH:0] ext;
    logic signed [HK_P_WIDTH:0] hi;
    logic signed [HK_P_WIDTH:0] lo;
    rss_t r;
    ext = {x[HK_P_WIDTH-1], x};
    if (sh != 6'd0) ext = ext + (HK_ONE << (sh - 6'd1));
    ext = ext >>> sh;
    hi = (HK_ONE << (ow - 1)) - HK_ONE;
    lo = -hi - HK_ONE;
    r.sat = 1'b0;
    r.val = ext;
    if (ext > hi) begin
      r.sat = 1'b1;
      r.val = hi;
    end else if (ext < lo) begin
      r.sat = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/dsp_psum_drain_fifo.sv
// Synchronous result FIFO with occupancy count; push and pop may coincide at any
// fill level, including full.
module psum_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/dsp_psum_drain.sv
// Accumulates groups of DSP partial sums, rounds/shifts/saturates each group
// result, and drains results through a FIFO over valid/ready.
module dsp_psum_drain
  import hakutpu_pkg::*;
#(
  parameter int P_WIDTH    = HK_P_WIDTH,
  parameter int OUT_WIDTH  = HK_OUT_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CNT_WIDTH-1:0]        cfg_k_len,
  input  logic [5:0]                  cfg_shift,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [P_WIDTH-1:0]   in_p,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        busy,
  output logic                        sat_flag,
  output logic                        acc_ovf
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic signed [P_WIDTH-1:0] acc_p1;
  logic [CNT_WIDTH-1:0]      cnt_p1;
  logic [CNT_WIDTH-1:0]      k_lat;
  logic [5:0]                sh_lat;
  logic signed [P_WIDTH-1:0] s2_p2;
  logic [5:0]                sh_p2;
  logic                      vld_p2;

  logic                      take;
  logic                      first;
  logic                      last;
  logic [CNT_WIDTH-1:0]      k_eff;
  logic [5:0]                sh_eff;
  logic signed [P_WIDTH-1:0] acc_in;
  logic signed [P_WIDTH-1:0] sum;
  logic                      ovf;
  rss_t                      rs_p2;
  logic [CW-1:0]             fifo_count;
  logic [OUT_WIDTH-1:0]      fifo_rdata;

  function automatic rss_t round_sat(input logic signed [P_WIDTH-1:0] x,
                                     input logic [5:0] sh);
    return round_shift_sat(x, sh, OUT_WIDTH);
  endfunction

  // Group config is taken live on the first beat, then from the latched copy.
  always_comb begin
    take   = in_valid && in_ready;
    first  = (cnt_p1 == '0);
    k_eff  = first ? ((cfg_k_len == '0) ? CNT_WIDTH'(1) : cfg_k_len) : k_lat;
    sh_eff = first ? cfg_shift : sh_lat;
    last   = (cnt_p1 == (k_eff - CNT_WIDTH'(1)));
    acc_in = first ? '0 : acc_p1;
    sum    = acc_in + in_p;
    ovf    = (acc_in[P_WIDTH-1] == in_p[P_WIDTH-1]) && (sum[P_WIDTH-1] != in_p[P_WIDTH-1]);
  end

  // S1: accumulate; final beat hands the group sum to S2
  always_ff @(posedge clk) begin
    if (take && first) begin
      k_lat  <= k_eff;
      sh_lat <= cfg_shift;
    end
    if (take) acc_p1 <= sum;
    if (take && last) begin
      s2_p2 <= sum;
      sh_p2 <= sh_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1   <= '0;
      vld_p2   <= 1'b0;
      acc_ovf  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      vld_p2 <= take && last;
      if (take) cnt_p1 <= last ? '0 : cnt_p1 + CNT_WIDTH'(1);
      if (take && ovf) acc_ovf <= 1'b1;
      if (vld_p2 && rs_p2.sat) sat_flag <= 1'b1;
    end
  end

  // S2: round/saturate and push; in_ready guarantees a free FIFO slot here
  always_comb rs_p2 = round_sat(s2_p2, sh_p2);

  psum_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p2),
    .wdata (rs_p2.val[OUT_WIDTH-1:0]),
    .pop   (out_valid && out_ready),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  always_comb begin
    out_valid = (fifo_count != '0);
    out_data  = out_valid ? $signed(fifo_rdata) : '0;
    in_ready  = ((fifo_count + CW'(vld_p2)) < CW'(FIFO_DEPTH));
    busy      = (cnt_p1 != '0) || vld_p2 || out_valid;
  end

endmodule

// File: tb/tb_dsp_psum_drain.sv
// Scoreboard bench for dsp_psum_drain: a group-level reference model queues
// expected results, a monitor compares every presented output.
module tb_dsp_psum_drain;

  logic               clk;
  logic               rst;
  logic [15:0]        cfg_k_len;
  logic [5:0]         cfg_shift;
  logic               in_valid;
  logic               in_ready;
  logic signed [47:0] in_p;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic               busy;
  logic               sat_flag;
  logic               acc_ovf;

  dsp_psum_drain dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_k_len (cfg_k_len),
    .cfg_shift (cfg_shift),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .sat_flag  (sat_flag),
    .acc_ovf   (acc_ovf)
  );

  int     errors = 0;
  int     checks = 0;
  int     n_pop  = 0;
  longint q[$];
  bit     rand_on = 0;

  int     m_cnt = 0, m_k = 1, m_sh = 0;
  longint m_sum = 0;
  bit     e_sat = 0, e_ovf = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint wrap48(input longint v);
    logic [47:0] t;
    t = v[47:0];
    return longint'($signed(t));
  endfunction

  function automatic longint expect_out(input longint s, input int sh, output bit sat);
    longint v;
    v = s;
    if (sh > 0) v = v + (64'sd1 <<< (sh - 1));
    v = v >>> sh;
    sat = 1'b0;
    if (v > 64'sd2147483647) begin
      v = 64'sd2147483647;
      sat = 1'b1;
    end else if (v < -64'sd2147483648) begin
      v = -64'sd2147483648;
      sat = 1'b1;
    end
    return v;
  endfunction

  task automatic model_accept(input longint p, input int k, input int sh);
    longint raw;
    bit     s;
    if (m_cnt == 0) begin
      m_k   = (k == 0) ? 1 : k;
      m_sh  = sh;
      m_sum = 0;
    end
    raw = m_sum + p;
    if (raw > (64'sd1 <<< 47) - 1 || raw < -(64'sd1 <<< 47)) e_ovf = 1'b1;
    m_sum = wrap48(raw);
    m_cnt++;
    if (m_cnt == m_k) begin
      q.push_back(expect_out(m_sum, m_sh, s));
      if (s) e_sat = 1'b1;
      m_cnt = 0;
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    e_sat = 1'b0;
    e_ovf = 1'b0;
    q.delete();
  endtask

  // Leaves in_valid high on return so successive calls form back-to-back beats.
  task automatic send_beat(input longint p, input int k, input int sh);
    int n;
    n = 0;
    cfg_k_len = 16'(k);
    cfg_shift = 6'(sh);
    in_p      = p[47:0];
    in_valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(p, k, sh);
        @(posedge clk);
        #1;
        return;
      end
      n++;
      if (n > 500) begin
        chk("beat_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", (n < 1000) ? 1 : 0, 1);
  endtask

  function automatic longint rand_p();
    longint r;
    case ($urandom_range(0, 3))
      0: r = longint'($urandom_range(0, 2000)) - 64'sd1000;
      1: r = longint'($signed($urandom));
      2: r = wrap48({$urandom, $urandom});
      default: begin
        if ($urandom_range(0, 1) == 1) r = (64'sd1 <<< 47) - 1 - longint'($urandom_range(0, 3));
        else                           r = -(64'sd1 <<< 47) + longint'($urandom_range(0, 3));
      end
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_output", longint'(out_data), 0);
      end else begin
        chk("out_data", longint'(out_data), q[0]);
        if (out_ready) begin
          void'(q.pop_front());
          n_pop++;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_p      = '0;
    cfg_k_len = 16'd1;
    cfg_shift = 6'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_ovf", acc_ovf, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // k=3 back-to-back, latency and busy
    send_beat(1, 3, 0);
    send_beat(2, 3, 0);
    send_beat(3, 3, 0);
    idle();
    chk("lat_valid_n", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_valid_n1", out_valid, 1);
    chk("lat_data", out_data, 6);
    @(posedge clk);
    #1;
    chk("lat_busy_after_pop", busy, 0);
    chk("lat_valid_after_pop", out_valid, 0);

    // k=1 rounding
    send_beat(6, 1, 2);
    send_beat(-6, 1, 2);
    send_beat(5, 1, 2);
    idle();
    drain();
    chk("round_sat_flag", sat_flag, 0);

    // positive and negative saturation
    send_beat(2147483647, 2, 0);
    send_beat(5, 2, 0);
    send_beat(-64'sd2147483649, 1, 0);
    idle();
    drain();
    chk("sat_flag_set", sat_flag, 1);

    // backpressure: four results fit, then in_ready drops
    out_ready = 1'b0;
    for (int i = 10; i < 14; i++) send_beat(i, 1, 0);
    idle();
    chk("bp_in_ready_full", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_in_ready_hold", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", out_data, 10);
    out_ready = 1'b1;
    send_beat(14, 1, 0);
    send_beat(15, 1, 0);
    idle();
    drain();

    // reset mid-group discards partial sum and clears flags
    send_beat(7, 3, 0);
    send_beat(7, 3, 0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sat", sat_flag, 0);
    chk("mid_rst_ovf", acc_ovf, 0);
    pops0 = n_pop;
    for (int i = 0; i < 3; i++) send_beat(1, 3, 0);
    idle();
    drain();
    chk("mid_rst_one_result", n_pop - pops0, 1);

    // accumulator wrap
    send_beat((64'sd1 <<< 47) - 1, 2, 0);
    send_beat(1, 2, 0);
    idle();
    drain();
    chk("ovf_flag", acc_ovf, 1);
    chk("ovf_sat_flag", sat_flag, 1);

    // randomized: cfg changes every beat (must latch per group), random gaps and backpressure
    rand_on = 1'b1;
    fork
      while (rand_on) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 400; i++) begin
      send_beat(rand_p(), $urandom_range(0, 4),
                ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 47));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
    end
    idle();
    // finish any open group so all queued results can drain
    while (m_cnt != 0) send_beat(rand_p(), 1, 0);
    idle();
    rand_on = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();
    chk("rand_sat_flag", sat_flag, e_sat);
    chk("rand_ovf_flag", acc_ovf, e_ovf);
    chk("rand_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
